// File: rtl/path_oram_channel_striper_pkg.sv
// Shared definitions for the Path ORAM multi-channel DRAM striper:
// command codes, log2 and the channel-local address width rule.
package path_oram_channel_striper_pkg;

    localparam int unsigned DDR3CMD_Write = 0;
    localparam int unsigned DDR3CMD_Read  = 1;

    // Ceiling log2; log2(1) = 0.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel-local addresses drop the channel-select bits.
    function automatic int unsigned local_aw(input int unsigned aw, input int unsigned nch);
        return aw - log2(nch);
    endfunction

    // Keeps index vectors at least one bit wide when a log2 is zero.
    function automatic int unsigned max1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/path_oram_channel_striper_chan.sv
// chan_id_fifo: small FIFO of channel ids, used to track read return order
// and the destination channel of writes still waiting for their data beat.
module chan_id_fifo
    import path_oram_channel_striper_pkg::*;
#(
    parameter  int unsigned Width = 1,
    parameter  int unsigned Depth = 16,
    localparam int unsigned CntW  = log2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = max1(log2(Depth));

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign push_ok = push_i && (count_q != CntW'(Depth));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/path_oram_channel_striper.sv
// Stripes the backend DRAM stream across NumChannels controllers by address
// bits and returns read beats strictly in command order.
module path_oram_channel_striper
    import path_oram_channel_striper_pkg::*;
#(
    parameter  int unsigned NumChannels = 2,
    parameter  int unsigned DDRAWidth   = 28,
    parameter  int unsigned DDRCWidth   = 3,
    parameter  int unsigned DDRDWidth   = 512,
    parameter  int unsigned ChanLSB     = 3,
    parameter  int unsigned OrderDepth  = 16,
    parameter  int unsigned WrDepth     = 16,
    localparam int unsigned CW          = log2(NumChannels),
    localparam int unsigned LAW         = local_aw(DDRAWidth, NumChannels),
    localparam int unsigned RifW        = log2(OrderDepth) + 1
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [DDRAWidth-1:0]             CmdAddress,
    input  logic [DDRCWidth-1:0]             Cmd,
    input  logic                             CmdValid,
    output logic                             CmdReady,
    input  logic [DDRDWidth-1:0]             WriteData,
    input  logic                             WriteDataValid,
    output logic                             WriteDataReady,
    output logic [DDRDWidth-1:0]             ReadData,
    output logic                             ReadDataValid,
    input  logic                             ReadDataReady,
    output logic [NumChannels*LAW-1:0]       CHCommandAddress,
    output logic [NumChannels*DDRCWidth-1:0] CHCommand,
    output logic [NumChannels-1:0]           CHCommandValid,
    input  logic [NumChannels-1:0]           CHCommandReady,
    output logic [NumChannels*DDRDWidth-1:0] CHWriteData,
    output logic [NumChannels-1:0]           CHWriteDataValid,
    input  logic [NumChannels-1:0]           CHWriteDataReady,
    input  logic [NumChannels*DDRDWidth-1:0] CHReadData,
    input  logic [NumChannels-1:0]           CHReadDataValid,
    output logic [NumChannels-1:0]           CHReadDataReady,
    output logic [RifW-1:0]                  ReadsInFlight
);

    localparam int unsigned SelW    = max1(CW);
    localparam int unsigned WrCntW  = log2(WrDepth) + 1;

    logic [SelW-1:0]      sel;
    logic [LAW-1:0]       local_addr;
    logic [DDRDWidth-1:0] rd_lane [NumChannels];
    logic [SelW-1:0]      ord_head, wr_head;
    logic [RifW-1:0]      ord_count;
    logic [WrCntW-1:0]    wr_count;
    logic                 ord_full, ord_empty, wr_full, wr_empty;
    logic                 is_read, is_write, room;
    logic                 ord_push, ord_pop, wr_push, wr_pop;

    function automatic logic [NumChannels-1:0] lane(input logic [SelW-1:0] s);
        return NumChannels'(1) << s;
    endfunction

    // Channel select and address compaction (select bits removed).
    if (CW == 0) begin : g_one_chan
        assign sel = '0;
    end else begin : g_multi_chan
        assign sel = SelW'(CmdAddress[ChanLSB +: CW]);
    end

    for (genvar i = 0; i < int'(LAW); i++) begin : g_addr
        if (i < int'(ChanLSB)) begin : g_low
            assign local_addr[i] = CmdAddress[i];
        end else begin : g_high
            assign local_addr[i] = CmdAddress[i + int'(CW)];
        end
    end

    for (genvar c = 0; c < int'(NumChannels); c++) begin : g_lane
        assign CHCommandAddress[c*LAW +: LAW]             = local_addr;
        assign CHCommand[c*DDRCWidth +: DDRCWidth]        = Cmd;
        assign CHWriteData[c*DDRDWidth +: DDRDWidth]      = WriteData;
        assign rd_lane[c] = CHReadData[c*DDRDWidth +: DDRDWidth];
    end

    assign is_read   = (Cmd == DDRCWidth'(DDR3CMD_Read));
    assign is_write  = (Cmd == DDRCWidth'(DDR3CMD_Write));
    assign ord_full  = (ord_count == RifW'(OrderDepth));
    assign ord_empty = (ord_count == '0);
    assign wr_full   = (wr_count == WrCntW'(WrDepth));
    assign wr_empty  = (wr_count == '0);
    assign room      = is_read ? !ord_full : (is_write ? !wr_full : 1'b1);

    // Handshake steering; every control output is forced low while in reset.
    always_comb begin
        CHCommandValid   = '0;
        CHWriteDataValid = '0;
        CHReadDataReady  = '0;
        CmdReady         = Reset && room && CHCommandReady[sel];
        WriteDataReady   = Reset && !wr_empty && CHWriteDataReady[wr_head];
        ReadDataValid    = Reset && !ord_empty && CHReadDataValid[ord_head];
        if (Reset && CmdValid && room) begin
            CHCommandValid = lane(sel);
        end
        if (Reset && !wr_empty && WriteDataValid) begin
            CHWriteDataValid = lane(wr_head);
        end
        if (Reset && !ord_empty && ReadDataReady) begin
            CHReadDataReady = lane(ord_head);
        end
    end

    assign ReadData      = rd_lane[ord_head];
    assign ord_push      = CmdValid && CmdReady && is_read;
    assign wr_push       = CmdValid && CmdReady && is_write;
    assign ord_pop       = ReadDataValid && ReadDataReady;
    assign wr_pop        = WriteDataValid && WriteDataReady;
    assign ReadsInFlight = ord_count;

    chan_id_fifo #(
        .Width (SelW),
        .Depth (OrderDepth)
    ) u_order_fifo (
        .clk     (Clock),
        .rst_n   (Reset),
        .push_i  (ord_push),
        .data_i  (sel),
        .pop_i   (ord_pop),
        .data_o  (ord_head),
        .count_o (ord_count)
    );

    chan_id_fifo #(
        .Width (SelW),
        .Depth (WrDepth)
    ) u_write_fifo (
        .clk     (Clock),
        .rst_n   (Reset),
        .push_i  (wr_push),
        .data_i  (sel),
        .pop_i   (wr_pop),
        .data_o  (wr_head),
        .count_o (wr_count)
    );

endmodule
